// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths, PC sequencer state encoding and
// instruction memory depth (shared with instruction_fetch).
package core_pkg;

   localparam int XLEN       = 64;
   localparam int INSTR_W    = 32;
   localparam int IMEM_WORDS = 1024;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HALT  = 2'd2,
      FAULT = 2'd3
   } pc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear.
// Ports:
//   clk    in  clock, rising edge
//   clr_n  in  synchronous clear, active-low
//   inc    in  advance by one (ignored once all-ones is reached)
//   count  out current value
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC, presents it to
// instruction_fetch and selects the next PC (+4, branch redirect, halt/fault).
// Optional feature macro: PC_TRAP_EN (invalid fetch address traps to TRAP_VEC
// and keeps running instead of stopping in FAULT).
// Ports:
//   clk, rst_n        clock / synchronous active-low reset
//   stall             hold pc this cycle
//   branch_taken      redirect request, target on branch_target
//   halt_req          ebreak/ecall stop request
//   inv_addr          fetch block flags current pc as invalid
//   pc, pc_plus4      current fetch address and its sequential successor
//   valid, halted     pc is live / sequencer stopped
//   fault, fault_pc   sticky invalid-fetch flag and the offending address
//   fetch_count       saturating count of pc advances
//
// state | meaning
// BOOT  | one cycle after reset release, pc = RESET_PC, not yet valid
// RUN   | fetching; pc advances, redirects or traps
// HALT  | stopped by halt_req, terminal until reset
// FAULT | stopped on invalid fetch address, terminal until reset
module pc_sequencer
   import core_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] TRAP_VEC = 64'h100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [XLEN-1:0]  branch_target,
   input  logic             halt_req,
   input  logic             inv_addr,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             valid,
   output logic             halted,
   output logic             fault,
   output logic [XLEN-1:0]  fault_pc,
   output logic [31:0]      fetch_count
);

   if ((RESET_PC[1:0] != 2'b00) || (TRAP_VEC[1:0] != 2'b00) || (TRAP_VEC >= 64'd4096)) begin : g_bad_param
      $error("pc_sequencer: RESET_PC/TRAP_VEC must be word-aligned, TRAP_VEC below 4096");
   end

   pc_state_t       state, state_nxt;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] fault_pc_nxt;
   logic            fault_nxt;
   logic            advance;

   assign pc_plus4 = pc + 64'd4;

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      fault_nxt    = fault;
      fault_pc_nxt = fault_pc;
      advance      = 1'b0;
      case (state)
         BOOT: state_nxt = RUN;
         RUN: begin
            if (inv_addr) begin
               fault_nxt    = 1'b1;
               fault_pc_nxt = pc;
`ifdef PC_TRAP_EN
               pc_nxt       = TRAP_VEC;
`else
               state_nxt    = FAULT;
`endif
            end else if (halt_req) begin
               state_nxt = HALT;
            end else if (stall) begin
               // a branch under stall is dropped; execute re-presents it
               pc_nxt = pc;
            end else if (branch_taken) begin
               pc_nxt  = branch_target;
               advance = 1'b1;
            end else begin
               pc_nxt  = pc_plus4;
               advance = 1'b1;
            end
         end
         HALT:    state_nxt = HALT;
         FAULT:   state_nxt = FAULT;
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= BOOT;
         pc       <= RESET_PC;
         valid    <= 1'b0;
         halted   <= 1'b0;
         fault    <= 1'b0;
         fault_pc <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         valid    <= (state_nxt == RUN);
         halted   <= (state_nxt == HALT) || (state_nxt == FAULT);
         fault    <= fault_nxt;
         fault_pc <= fault_pc_nxt;
      end
   end

   // reset doubles as the counter clear so no advance is honoured on a reset edge
   sat_counter #(.WIDTH(32)) u_fetch_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (advance & rst_n),
      .count (fetch_count)
   );

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

   localparam logic [63:0] RESET_PC = 64'h0;
   localparam logic [63:0] TRAP_VEC = 64'h100;
   localparam logic [63:0] IMEM_BYTES = 64'(core_pkg::IMEM_WORDS) * 64'd4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [63:0] branch_target = '0;
   logic        halt_req = 1'b0;
   logic        inv_addr = 1'b0;
   logic [63:0] pc, pc_plus4, fault_pc;
   logic        valid, halted, fault;
   logic [31:0] fetch_count;

   int vectors = 0;
   int miscompares = 0;

   // reference model: running / stopped view, no notion of the RTL encoding
   typedef enum {M_BOOT, M_RUN, M_STOP} m_phase_t;
   m_phase_t    m_phase;
   logic [63:0] m_pc, m_fpc;
   logic        m_fault;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halt_req      (halt_req),
      .inv_addr      (inv_addr),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .valid         (valid),
      .halted        (halted),
      .fault         (fault),
      .fault_pc      (fault_pc),
      .fetch_count   (fetch_count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic bad_addr(input logic [63:0] a);
      return (a[1:0] != 2'b00) || (a >= IMEM_BYTES);
   endfunction

   function automatic void model_step(input logic rn, input logic st, input logic br,
                                      input logic [63:0] tgt, input logic hr, input logic inv);
      if (!rn) begin
         m_phase = M_BOOT; m_pc = RESET_PC; m_fault = 1'b0; m_fpc = '0; m_cnt = '0;
      end else if (m_phase == M_BOOT) begin
         m_phase = M_RUN;
      end else if (m_phase == M_RUN) begin
         if (inv) begin
            m_fault = 1'b1;
            m_fpc   = m_pc;
`ifdef PC_TRAP_EN
            m_pc    = TRAP_VEC;
`else
            m_phase = M_STOP;
`endif
         end else if (hr) begin
            m_phase = M_STOP;
         end else if (!st) begin
            m_pc = br ? tgt : m_pc + 64'd4;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
         end
      end
   endfunction

   task automatic compare_all();
      check("pc",          pc,          m_pc);
      check("pc_plus4",    pc_plus4,    m_pc + 64'd4);
      check("valid",       64'(valid),  64'(m_phase == M_RUN));
      check("halted",      64'(halted), 64'(m_phase == M_STOP));
      check("fault",       64'(fault),  64'(m_fault));
      check("fault_pc",    fault_pc,    m_fpc);
      check("fetch_count", 64'(fetch_count), 64'(m_cnt));
   endtask

   task automatic step(input logic rn, input logic st, input logic br,
                       input logic [63:0] tgt, input logic hr);
      logic inv;
      @(negedge clk);
      inv = bad_addr(m_pc);
      rst_n = rn; stall = st; branch_taken = br; branch_target = tgt;
      halt_req = hr; inv_addr = inv;
      @(posedge clk);
      model_step(rn, st, br, tgt, hr, inv);
      #1;
      compare_all();
   endtask

   task automatic idle(); step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0); endtask

   initial begin
      logic [63:0] tgt;
      m_phase = M_BOOT; m_pc = RESET_PC; m_fault = 1'b0; m_fpc = '0; m_cnt = '0;

      // reset, BOOT, then free-run
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      check("boot_valid", 64'(valid), 64'd0);
      check("boot_pc", pc, 64'h0);
      idle(); check("run_pc0", pc, 64'h0);
      idle(); check("run_pc4", pc, 64'h4);
      idle(); check("run_pc8", pc, 64'h8);
      idle(); check("run_pc12", pc, 64'hC);
      check("cnt_after3", 64'(fetch_count), 64'd3);

      // branch at pc=8, first stalled then taken
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      idle(); idle(); idle();
      check("pre_br_pc", pc, 64'h8);
      step(1'b1, 1'b1, 1'b1, 64'h40, 1'b0);
      check("stall_br_pc", pc, 64'h8);
      check("stall_br_cnt", 64'(fetch_count), 64'd2);
      step(1'b1, 1'b0, 1'b1, 64'h40, 1'b0);
      check("br_pc", pc, 64'h40);

      // misaligned target, caught on the following cycle
      step(1'b1, 1'b0, 1'b1, 64'h42, 1'b0);
      idle();
`ifdef PC_TRAP_EN
      check("trap_pc", pc, 64'h100);
      check("trap_valid", 64'(valid), 64'd1);
`else
      check("fault_halted", 64'(halted), 64'd1);
      check("fault_pc_hold", pc, 64'h42);
`endif
      check("fault_addr", fault_pc, 64'h42);
      for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom), 1'($urandom), 64'h80, 1'($urandom));

      // reset out of FAULT/trap
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      check("rst_fault", 64'(fault), 64'd0);
      check("rst_halted", 64'(halted), 64'd0);
      idle(); check("rst_run_valid", 64'(valid), 64'd1);

      // halt at pc=0x10 ignores later branches
      for (int i = 0; i < 4; i++) idle();
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 1'(i % 2 == 0), 64'h200, 1'b0);
         check("halt_pc", pc, 64'h10);
         check("halt_halted", 64'(halted), 64'd1);
      end

      // saturation of fetch_count
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      idle();
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
      force dut.u_fetch_cnt.count = 32'hFFFF_FFFE;
      #1;
      release dut.u_fetch_cnt.count;
      m_cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) idle();
      check("cnt_sat", 64'(fetch_count), 64'hFFFF_FFFF);

      // randomized traffic with occasional resets
      step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0);
      for (int n = 0; n < 600; n++) begin
         case ($urandom_range(0, 19))
            0, 1, 2:  tgt = {$urandom, $urandom};
            3, 4, 5:  tgt = 64'($urandom_range(0, 4095));
            default:  tgt = 64'($urandom_range(0, 1023)) << 2;
         endcase
         step(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 3) == 0), tgt, 1'($urandom_range(0, 59) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the sequential RV64 core: holds the architectural PC, drives it into `instruction_fetch`, and selects the next PC. Next-PC sources are sequential (+4), branch/jump redirect, and the fault/halt path. It sits directly upstream of `instruction_fetch`, consumes that block's `invAddr` flag, and feeds decode with `pc`/`pc_plus4`.

## Interface
Parameters:
- `RESET_PC`, 64'h0: PC loaded on reset; must be word-aligned.
- `TRAP_VEC`, 64'h100: fault redirect target (used only with `PC_TRAP_EN`); must be word-aligned and below 4096.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `stall`  in  1  hold current PC this cycle.
- `branch_taken`  in  1  redirect request from execute.
- `branch_target`  in  64  redirect address.
- `halt_req`  in  1  ebreak/ecall halt request from decode.
- `inv_addr`  in  1  `invAddr` from `instruction_fetch` for the current `pc`.
- `pc`  out  64  current fetch address to `instruction_fetch`.
- `pc_plus4`  out  64  `pc + 4`, combinational, wraps modulo 2^64.
- `valid`  out  1  `pc` is a live fetch address.
- `halted`  out  1  sequencer is stopped.
- `fault`  out  1  sticky; an invalid fetch address was seen.
- `fault_pc`  out  64  address that faulted.
- `fetch_count`  out  32  count of PC advances, saturating.

## Operation
- FSM states: BOOT, RUN, HALT, FAULT.
- BOOT: lasts one cycle after reset release. `valid` is 0. Moves to RUN. `pc` is held at `RESET_PC`.
- RUN: `valid` is 1. Per-cycle priority, highest first:
  1. `inv_addr`: capture `fault_pc <= pc` and set `fault`. With `PC_TRAP_EN`, set `pc <= TRAP_VEC` and stay in RUN. Without it, go to FAULT.
  2. `halt_req`: go to HALT; `pc` held.
  3. `stall`: `pc` held.
  4. `branch_taken`: `pc <= branch_target`. No alignment check here; a misaligned target is caught by `inv_addr` on the next cycle.
  5. Otherwise: `pc <= pc_plus4`.
- `fetch_count` increments only on cases 4 and 5. Holds at 32'hFFFF_FFFF once reached.
- HALT and FAULT are terminal until reset. In both, `valid` is 0, `halted` is 1, and all inputs are ignored.
- `inv_addr` is ignored outside RUN.
- In FAULT, `pc` holds the faulting address.

## Timing
- Reset values, applied when `rst_n`=0 at a clk edge:
  - `pc` = `RESET_PC`; state = BOOT; `valid` = 0; `halted` = 0; `fault` = 0; `fault_pc` = 0; `fetch_count` = 0.
- Reset asserted mid-run or in HALT/FAULT aborts at the next edge to these values. No input is honoured on that edge.
- All outputs except `pc_plus4` are registered.
- Redirect latency is 1 cycle: `branch_taken` sampled at edge N gives `pc = branch_target` after edge N.
- `inv_addr` is combinational from the current `pc`, so a bad PC is acted on at the same edge it is presented. No fetch from a bad PC is ever counted.
- Simultaneous `stall` and `branch_taken`: the stall wins and the branch is dropped. Execute must hold `branch_taken` until a non-stalled cycle.

## Configuration
- `PC_TRAP_EN` defined: an invalid address redirects to `TRAP_VEC`, `fault` and `fault_pc` update, and execution continues in RUN. A later fault overwrites `fault_pc`.
- `PC_TRAP_EN` undefined: an invalid address enters FAULT and `halted` goes to 1. The `TRAP_VEC` parameter is unused.

## Structure
- Shared package `core_pkg` holds:
  - `XLEN` = 64 and `INSTR_W` = 32.
  - State enum `pc_state_t` {BOOT, RUN, HALT, FAULT}.
  - Constant `IMEM_WORDS` = 1024, shared with `instruction_fetch`.
- One sub-module, `sat_counter`, parameterised by width, with `inc` and synchronous active-low clear. It implements `fetch_count`.

## Test plan
- Reset then free-run 4 cycles, `RESET_PC`=0:
  - BOOT cycle: `valid`=0, `pc`=0.
  - Then `pc` = 0, 4, 8, 12.
  - `fetch_count`=3 after the third advance.
- `branch_taken`=1 with `branch_target`=0x40 at `pc`=8: next `pc`=0x40. Same request with `stall`=1: `pc` stays 8 and the count is unchanged.
- `branch_target`=0x42, `inv_addr` driven high the next cycle:
  - Without `PC_TRAP_EN`: FAULT, `halted`=1, `fault_pc`=0x42, `pc` holds 0x42.
  - With `PC_TRAP_EN`: `pc`=0x100, `valid`=1.
- `halt_req` at `pc`=0x10: `halted`=1 and `pc` stays 0x10 for 5 cycles despite `branch_taken` pulses.
- Preload `fetch_count` to 32'hFFFF_FFFE via force, advance 3 times: reads 32'hFFFF_FFFF.
- `rst_n`=0 for one edge while in FAULT: `pc`=`RESET_PC`, `fault`=0, `halted`=0, BOOT then RUN.
